// File: rtl/decompressor_multi.sv
// Instruction decompressor: passes plain words through and expands marker tokens
// into up to MAXEXP words held in a writable token table.
`timescale 1ns/1ps
module decompressor_multi #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] PCADD = 32'b100,
  parameter int encodeLength = 4,
  parameter logic [encodeLength-1:0] OPcode = 4'b1111,
  parameter int MAXEXP = 4,
  parameter int TOKENS = 64,
  localparam int IDXW = $clog2(TOKENS),
  localparam int LENW = $clog2(MAXEXP),
  localparam int AW = IDXW + LENW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic [WIDTH-1:0] PCcpu,
  input  logic [WIDTH-1:0] NextInstr,
  input  logic             wme,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] PCcompress,
  output logic [WIDTH-1:0] DecompressInstr,
  output logic             out_valid
);

  typedef enum logic [1:0] {IDLE, WAIT, DECODE} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] tbl [TOKENS*MAXEXP];
  logic [WIDTH-1:0] cptr;
  logic [WIDTH-1:0] last_pc;
  logic [LENW-1:0]  rem;
  logic [LENW-1:0]  k;
  logic [AW-1:0]    tbase;
  logic             first;

  logic             accept;
  logic             redirect;
  logic             is_token;
  logic [IDXW-1:0]  tok_idx;
  logic [LENW-1:0]  tok_lenm1;
  logic [AW-1:0]    tok_base;
  logic [AW-1:0]    hit_addr;
  logic             unused_bits;

  // A request is ignored in the cycle its predecessor's response is presented.
  assign accept    = (state == IDLE) && cpu_req && !out_valid;
  assign redirect  = first || (PCcpu != last_pc + PCADD);
  assign is_token  = (NextInstr[WIDTH-1 -: encodeLength] == OPcode);
  assign tok_idx   = NextInstr[IDXW-1:0];
  assign tok_lenm1 = NextInstr[AW-1:IDXW];
  assign tok_base  = {tok_idx, {LENW{1'b0}}};
  assign hit_addr  = tbase + AW'(k);
  assign unused_bits = ^NextInstr[WIDTH-encodeLength-1:AW];

  // Token table is not reset; new data is visible to reads from the next cycle.
  always_ff @(posedge clk) begin
    if (wme) tbl[waddr] <= WriteData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && (redirect || rem == '0)) next_state = WAIT;
      WAIT:    next_state = DECODE;
      DECODE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first           <= 1'b1;
      PCcompress      <= '0;
      DecompressInstr <= '0;
      out_valid       <= 1'b0;
      cptr            <= '0;
      last_pc         <= '1;
      rem             <= '0;
      k               <= '0;
      tbase           <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (redirect) begin
              rem        <= '0;
              PCcompress <= PCcpu;
            end else if (rem != '0) begin
              DecompressInstr <= tbl[hit_addr];
              k               <= k + LENW'(1);
              rem             <= rem - LENW'(1);
              last_pc         <= PCcpu;
              out_valid       <= 1'b1;
            end else begin
              PCcompress <= cptr;
            end
          end
        end
        DECODE: begin
          if (is_token) begin
            DecompressInstr <= tbl[tok_base];
            tbase           <= tok_base;
            k               <= LENW'(1);
            rem             <= tok_lenm1;
          end else begin
            DecompressInstr <= NextInstr;
            rem             <= '0;
          end
          cptr      <= PCcompress + PCADD;
          last_pc   <= PCcpu;
          first     <= 1'b0;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decompressor_multi.sv
// Directed bench for decompressor_multi: fetch, token expansion, table write,
// hold, branch and reset behaviour against hand-computed responses.
`timescale 1ns/1ps
module tb_decompressor_multi;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic [31:0] PCcpu;
  logic [31:0] NextInstr;
  logic        wme;
  logic [7:0]  waddr;
  logic [31:0] WriteData;
  logic [31:0] PCcompress;
  logic [31:0] DecompressInstr;
  logic        out_valid;

  int vectors;
  int miscompares;

  decompressor_multi dut (
    .clk(clk),
    .reset(reset),
    .cpu_req(cpu_req),
    .PCcpu(PCcpu),
    .NextInstr(NextInstr),
    .wme(wme),
    .waddr(waddr),
    .WriteData(WriteData),
    .PCcompress(PCcompress),
    .DecompressInstr(DecompressInstr),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compressed memory image; data follows the address one clock later.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h100: return 32'h00A00093;
      32'h104: return 32'hF00000C5;
      32'h108: return 32'hF00000C6;
      32'h200: return 32'h00200193;
      32'h204: return 32'hF0000002;
      32'h208: return 32'h00300213;
      default: return 32'h00000013;
    endcase
  endfunction

  always @(posedge clk) NextInstr <= memWord(PCcompress);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Issues one request, waits for the response and checks data, latency and
  // the compressed address seen one cycle after acceptance.
  task automatic applyStimulus(input string tag, input logic [31:0] pc,
                               input logic [31:0] expInstr, input int expLat,
                               input logic [31:0] expPcc);
    int cycles;
    bit seen;
    logic [31:0] pccAtAccept;
    @(negedge clk);
    wme = 1'b0;
    cpu_req = 1'b1;
    PCcpu = pc;
    cycles = 0;
    seen = 1'b0;
    pccAtAccept = 'x;
    while (!seen && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) pccAtAccept = PCcompress;
      if (out_valid) seen = 1'b1;
    end
    cpu_req = 1'b0;
    checkOutput({tag, "_valid"}, 32'(seen), 32'd1);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(expLat));
    checkOutput({tag, "_instr"}, DecompressInstr, expInstr);
    checkOutput({tag, "_pcc"}, pccAtAccept, expPcc);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    cpu_req = 1'b0;
    PCcpu = '0;
    wme = 1'b0;
    waddr = '0;
    WriteData = '0;
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_pcc", PCcompress, 32'd0);
    checkOutput("rst_instr", DecompressInstr, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      wme = 1'b1;
      waddr = 8'(i);
      WriteData = 32'hA0000000 | 32'(i);
    end
    @(negedge clk);
    wme = 1'b0;

    applyStimulus("plain100", 32'h100, 32'h00A00093, 3, 32'h100);
    applyStimulus("tok_w1", 32'h104, 32'hA0000014, 3, 32'h104);
    applyStimulus("tok_w2", 32'h108, 32'hA0000015, 1, 32'h104);

    // Overwrite word 3 of token 5 while word 2 is being presented.
    wme = 1'b1;
    waddr = 8'd22;
    WriteData = 32'hDEADBEEF;
    applyStimulus("tok_w3_written", 32'h10C, 32'hDEADBEEF, 1, 32'h104);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(out_valid), 32'd0);
      checkOutput("hold_pcc", PCcompress, 32'h104);
    end
    applyStimulus("tok_w4_after_hold", 32'h110, 32'hA0000017, 1, 32'h104);

    applyStimulus("tok6_w1", 32'h114, 32'hA0000018, 3, 32'h108);
    applyStimulus("tok6_w2", 32'h118, 32'hA0000019, 1, 32'h108);
    applyStimulus("branch200", 32'h200, 32'h00200193, 3, 32'h200);
    applyStimulus("len1_token", 32'h204, 32'hA0000008, 3, 32'h204);
    applyStimulus("after_len1", 32'h208, 32'h00300213, 3, 32'h208);

    // Reset while the fetch for 0x20C is in flight.
    @(negedge clk);
    cpu_req = 1'b1;
    PCcpu = 32'h20C;
    @(negedge clk);
    checkOutput("midrst_pcc_before", PCcompress, 32'h20C);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_pcc", PCcompress, 32'd0);
    checkOutput("midrst_instr", DecompressInstr, 32'd0);
    cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("midrst_hold_valid", 32'(out_valid), 32'd0);
    end
    reset = 1'b1;
    applyStimulus("post_reset100", 32'h100, 32'h00A00093, 3, 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
